// File: rtl/arf_seq_engine.sv
// arf_seq_engine: time-shared lattice filter engine.
// Accepts a frame of eight samples x1..x8, computes two results y0/y1 over a
// fixed 16-step schedule using one multiplier and one adder, then presents
// y0 and y1 on a valid/ready output port. z1/z2 carry feedback between frames.
//
// Ports:
//   clk, rst_n         clock, async active-low reset
//   clear              sync abort: drop partial frame, zero feedback, go LOAD
//   s_valid/s_ready    sample handshake, s_data carries x1..x8 in order
//   m_valid/m_ready    result handshake, m_data carries y0 then y1
//   busy               high in every state except LOAD
//
// state   | meaning
// --------+-----------------------------------------------------------
// LOAD    | accept x1..x8, form m_i = x_i*C_IN on arrival
// COMPUTE | 16-step schedule over the scratch file (ccnt 0..15)
// OUT0    | first cycle loads y0 into output reg, then waits handshake
// OUT1    | present y1, handshake returns to LOAD
module arf_seq_engine #(
  parameter int W = 16,
  parameter logic [W-1:0] C_IN  = 16'd3,
  parameter logic [W-1:0] C_MID = 16'd3,
  parameter logic [W-1:0] C_NEG = 16'hFFFD,
  parameter logic [W-1:0] C_POS = 16'd3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [W-1:0] s_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [W-1:0] m_data,
  output logic         busy
);

  typedef enum logic [1:0] {LOAD, COMPUTE, OUT0, OUT1} state_t;

  state_t         state_q, state_d;
  logic [2:0]     scnt_q, scnt_d;
  logic [3:0]     ccnt_q, ccnt_d;
  logic [W-1:0]   z1_q, z1_d, z2_q, z2_d;
  logic           m_valid_q, m_valid_d;
  logic [W-1:0]   m_data_q, m_data_d;
  logic           live_q;
  logic [W-1:0]   sc_q [16];

  logic           s_fire, m_fire;
  logic           add_en, mul_en;
  logic [4:0]     add_a, add_b;
  logic [3:0]     add_dst, mul_src, mul_dst;
  logic [1:0]     mul_k;
  logic [W-1:0]   opa, opb, mul_x, coef, sum, prod;

  // live_q keeps s_ready low until the first edge after reset release
  assign s_ready = live_q && (state_q == LOAD) && !clear;
  assign s_fire  = s_valid && s_ready;
  assign m_fire  = m_valid_q && m_ready && !clear;
  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign busy    = (state_q != LOAD);

  // Schedule. Scratch slots 0..7 hold m1..m8 after LOAD; operand codes 16/17
  // select z1/z2. Results land in slots 12 (y0) and 13 (y1); n19/n20 in 5/7.
  always_comb begin
    add_en  = 1'b0;
    mul_en  = 1'b0;
    add_a   = 5'd0;
    add_b   = 5'd0;
    add_dst = 4'd0;
    mul_src = 4'd0;
    mul_dst = 4'd0;
    mul_k   = 2'd0;
    if (state_q == LOAD) begin
      mul_en  = s_fire;
      mul_dst = {1'b0, scnt_q};
    end else if (state_q == COMPUTE) begin
      case (ccnt_q)
        4'd0:  begin add_en = 1'b1; add_a = 5'd0;  add_b = 5'd1;  add_dst = 4'd8;  end
        4'd1:  begin add_en = 1'b1; add_a = 5'd2;  add_b = 5'd3;  add_dst = 4'd9;  end
        4'd2:  begin add_en = 1'b1; add_a = 5'd4;  add_b = 5'd5;  add_dst = 4'd10; end
        4'd3:  begin add_en = 1'b1; add_a = 5'd6;  add_b = 5'd7;  add_dst = 4'd11; end
        4'd4:  begin add_en = 1'b1; add_a = 5'd9;  add_b = 5'd16; add_dst = 4'd0;  end
        4'd5:  begin
          add_en = 1'b1; add_a = 5'd10; add_b = 5'd17; add_dst = 4'd1;
          mul_en = 1'b1; mul_src = 4'd0; mul_k = 2'd1; mul_dst = 4'd2;
        end
        4'd6:  begin mul_en = 1'b1; mul_src = 4'd1; mul_k = 2'd1; mul_dst = 4'd3; end
        4'd7:  begin
          mul_en = 1'b1; mul_src = 4'd0; mul_k = 2'd1; mul_dst = 4'd4;
          add_en = 1'b1; add_a = 5'd2; add_b = 5'd3; add_dst = 4'd5;
        end
        4'd8:  begin mul_en = 1'b1; mul_src = 4'd1; mul_k = 2'd1; mul_dst = 4'd6; end
        4'd9:  begin
          add_en = 1'b1; add_a = 5'd4; add_b = 5'd6; add_dst = 4'd7;
          mul_en = 1'b1; mul_src = 4'd5; mul_k = 2'd2; mul_dst = 4'd12;
        end
        4'd10: begin mul_en = 1'b1; mul_src = 4'd7; mul_k = 2'd2; mul_dst = 4'd13; end
        4'd11: begin mul_en = 1'b1; mul_src = 4'd5; mul_k = 2'd2; mul_dst = 4'd14; end
        4'd12: begin
          mul_en = 1'b1; mul_src = 4'd7; mul_k = 2'd3; mul_dst = 4'd15;
          add_en = 1'b1; add_a = 5'd12; add_b = 5'd13; add_dst = 4'd9;
        end
        4'd13: begin add_en = 1'b1; add_a = 5'd14; add_b = 5'd15; add_dst = 4'd10; end
        4'd14: begin add_en = 1'b1; add_a = 5'd8;  add_b = 5'd9;  add_dst = 4'd12; end
        default: begin add_en = 1'b1; add_a = 5'd11; add_b = 5'd10; add_dst = 4'd13; end
      endcase
    end
  end

  assign opa   = add_a[4] ? (add_a[0] ? z2_q : z1_q) : sc_q[add_a[3:0]];
  assign opb   = add_b[4] ? (add_b[0] ? z2_q : z1_q) : sc_q[add_b[3:0]];
  assign mul_x = (state_q == LOAD) ? s_data : sc_q[mul_src];

  always_comb begin
    case (mul_k)
      2'd0:    coef = C_IN;
      2'd1:    coef = C_MID;
      2'd2:    coef = C_NEG;
      default: coef = C_POS;
    endcase
  end

  assign sum  = opa + opb;
  assign prod = mul_x * coef;

  always_comb begin
    state_d   = state_q;
    scnt_d    = scnt_q;
    ccnt_d    = ccnt_q;
    z1_d      = z1_q;
    z2_d      = z2_q;
    m_valid_d = 1'b0;
    m_data_d  = '0;
    case (state_q)
      LOAD: begin
        if (s_fire) begin
          scnt_d = scnt_q + 3'd1;
          if (scnt_q == 3'd7) begin
            state_d = COMPUTE;
            ccnt_d  = 4'd0;
          end
        end
      end
      COMPUTE: begin
        ccnt_d = ccnt_q + 4'd1;
        if (ccnt_q == 4'd15) begin
          state_d = OUT0;
          z1_d    = sc_q[5];
          z2_d    = sc_q[7];
        end
      end
      OUT0: begin
        // output regs load y0 on the first OUT0 cycle, y1 on the handshake
        m_valid_d = 1'b1;
        if (m_fire) begin
          m_data_d = sc_q[13];
          state_d  = OUT1;
        end else begin
          m_data_d = sc_q[12];
        end
      end
      default: begin
        if (m_fire) begin
          state_d = LOAD;
          scnt_d  = 3'd0;
        end else begin
          m_valid_d = 1'b1;
          m_data_d  = sc_q[13];
        end
      end
    endcase
    if (clear) begin
      state_d   = LOAD;
      scnt_d    = 3'd0;
      ccnt_d    = 4'd0;
      z1_d      = '0;
      z2_d      = '0;
      m_valid_d = 1'b0;
      m_data_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= LOAD;
      scnt_q    <= 3'd0;
      ccnt_q    <= 4'd0;
      z1_q      <= '0;
      z2_q      <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      live_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      scnt_q    <= scnt_d;
      ccnt_q    <= ccnt_d;
      z1_q      <= z1_d;
      z2_q      <= z2_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      live_q    <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) sc_q[i] <= '0;
    end else begin
      if (add_en) sc_q[add_dst] <= sum;
      if (mul_en) sc_q[mul_dst] <= prod;
    end
  end

endmodule

// File: tb/tb_arf_seq_engine.sv
module tb_arf_seq_engine;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         clear = 1'b0;
  logic         s_valid = 1'b0;
  logic         s_ready;
  logic [W-1:0] s_data = '0;
  logic         m_valid;
  logic         m_ready = 1'b1;
  logic [W-1:0] m_data;
  logic         busy;

  arf_seq_engine #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int t8 = 0;
  logic [15:0] exq[$];
  logic [15:0] mz1 = '0;
  logic [15:0] mz2 = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // reference model straight from the frame equations
  task automatic model(input logic [7:0][15:0] x, output logic [15:0] y0, output logic [15:0] y1);
    logic [15:0] m [8];
    logic [15:0] n9, n10, n11, n12, n13, n14, n15, n16, n17, n18;
    logic [15:0] n19, n20, n21, n22, n23, n24, n25, n26;
    for (int i = 0; i < 8; i++) m[i] = x[i] * 16'd3;
    n9  = m[0] + m[1];
    n10 = m[2] + m[3];
    n11 = m[4] + m[5];
    n12 = m[6] + m[7];
    n13 = n10 + mz1;
    n14 = n11 + mz2;
    n15 = n13 * 16'd3;
    n16 = n14 * 16'd3;
    n17 = n13 * 16'd3;
    n18 = n14 * 16'd3;
    n19 = n15 + n16;
    n20 = n17 + n18;
    n21 = n19 * 16'hFFFD;
    n22 = n20 * 16'hFFFD;
    n23 = n19 * 16'hFFFD;
    n24 = n20 * 16'd3;
    n25 = n21 + n22;
    n26 = n23 + n24;
    y0  = n9 + n25;
    y1  = n12 + n26;
    mz1 = n19;
    mz2 = n20;
  endtask

  task automatic send(input logic [7:0][15:0] x, input int cnt);
    for (int i = 0; i < cnt; i++) begin
      int n;
      logic acc;
      n = 0;
      acc = 1'b0;
      s_valid = 1'b1;
      s_data = x[i];
      while (!acc) begin
        @(negedge clk);
        acc = s_ready;
        @(posedge clk);
        #1;
        n++;
        if (n > 200) begin
          $display("FAIL send_timeout: sample %0d not accepted, got none want accept", i);
          $display("test done: total=%0d bad=%0d", total + 1, bad + 1);
          $fatal(1, "timeout");
        end
      end
    end
    s_valid = 1'b0;
    t8 = cyc;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exq.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain", exq.size(), 0);
    exq.delete();
    @(posedge clk);
    #1;
  endtask

  // output monitor: scoreboard pops, hold stability, latency, idle zero
  logic        pv = 1'b0;
  logic        pr = 1'b0;
  logic [15:0] pd = '0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (!m_valid) chk("m_data_idle", m_data, 0);
      if (busy) chk("s_ready_busy", s_ready, 0);
      if (pv && !pr) begin
        chk("hold_valid", m_valid, 1);
        chk("hold_data", m_data, pd);
      end
      if (m_valid && !pv) chk("latency", cyc - t8, 17);
      if (m_valid && m_ready) begin
        if (exq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_out: got %0h want no output", m_data);
        end else begin
          chk("result", m_data, exq.pop_front());
        end
      end
      pv = m_valid;
      pr = m_ready;
      pd = m_data;
    end else begin
      pv = 1'b0;
      pr = 1'b0;
      pd = '0;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0][15:0] x;
    logic             pre_clr;
    logic             use_model;
    logic [15:0]      y0;
    logic [15:0]      y1;
  } vec_t;

  vec_t vecs [6];
  logic [7:0][15:0] ones;
  logic [7:0][15:0] xr;
  logic [15:0] y0m, y1m;

  initial begin
    ones = {8{16'h0001}};
    vecs[0] = '{x: ones, pre_clr: 1'b0, use_model: 1'b0, y0: 16'hFF2E, y1: 16'h0006};
    vecs[1] = '{x: ones, pre_clr: 1'b0, use_model: 1'b0, y0: 16'hFA1E, y1: 16'h0006};
    vecs[2] = '{x: '0, pre_clr: 1'b1, use_model: 1'b0, y0: 16'h8000, y1: 16'h0000};
    vecs[2].x[0] = 16'h8000;
    for (int i = 3; i < 6; i++) begin
      vecs[i].pre_clr = (i == 4);
      vecs[i].use_model = 1'b1;
      vecs[i].y0 = '0;
      vecs[i].y1 = '0;
      for (int j = 0; j < 8; j++) vecs[i].x[j] = 16'($urandom);
    end

    // reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_s_ready", s_ready, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("s_ready_pre_edge", s_ready, 0);
    @(posedge clk);
    #1;
    chk("s_ready_first_edge", s_ready, 1);

    for (int i = 0; i < 6; i++) begin
      if (vecs[i].pre_clr) begin
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        mz1 = '0;
        mz2 = '0;
      end
      model(vecs[i].x, y0m, y1m);
      if (vecs[i].use_model) begin
        exq.push_back(y0m);
        exq.push_back(y1m);
      end else begin
        exq.push_back(vecs[i].y0);
        exq.push_back(vecs[i].y1);
      end
      send(vecs[i].x, 8);
      drain();
    end

    // backpressure in OUT0: y0 held, no sample accepted, y1 only after handshake
    for (int j = 0; j < 8; j++) xr[j] = 16'($urandom);
    model(xr, y0m, y1m);
    exq.push_back(y0m);
    exq.push_back(y1m);
    m_ready = 1'b0;
    send(xr, 8);
    begin
      int n;
      n = 0;
      while (!m_valid && n < 60) begin
        @(negedge clk);
        n++;
      end
    end
    chk("bp_valid_seen", m_valid, 1);
    repeat (5) begin
      @(negedge clk);
      chk("bp_data_y0", m_data, y0m);
      chk("bp_s_ready", s_ready, 0);
    end
    @(posedge clk);
    #1;
    m_ready = 1'b1;
    drain();

    // clear coincident with a sample after x4: sample dropped, fresh frame follows
    send(ones, 4);
    s_valid = 1'b1;
    s_data = 16'h1234;
    clear = 1'b1;
    @(negedge clk);
    chk("clr_s_ready", s_ready, 0);
    @(posedge clk);
    #1;
    clear = 1'b0;
    s_valid = 1'b0;
    mz1 = '0;
    mz2 = '0;
    model(ones, y0m, y1m);
    exq.push_back(16'hFF2E);
    exq.push_back(16'h0006);
    send(ones, 8);
    drain();

    // reset mid-COMPUTE: nothing emitted, feedback zeroed
    send(ones, 8);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_m_valid", m_valid, 0);
    chk("abort_busy", busy, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mz1 = '0;
    mz2 = '0;
    repeat (25) @(posedge clk);
    #1;
    chk("abort_no_valid", m_valid, 0);
    model(ones, y0m, y1m);
    exq.push_back(16'hFF2E);
    exq.push_back(16'h0006);
    send(ones, 8);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/arf_seq_engine.md
ARF_SEQ_ENGINE -- requirements
Module: arf_seq_engine

Interface
REQ-001 Parameters SHALL be (name, default, meaning): W, 16, data width; C_IN, 16'd3, coefficient of multipliers 1-8; C_MID, 16'd3, coefficient of multipliers 15-18; C_NEG, 16'hFFFD, coefficient of multipliers 21-23; C_POS, 16'd3, coefficient of multiplier 24.
REQ-002 Ports SHALL be (name, direction, width, meaning):
  clk      in   1   single clock, rising edge
  rst_n    in   1   asynchronous active-low reset
  clear    in   1   synchronous: discard partial frame, zero feedback state
  s_valid  in   1   input sample valid
  s_ready  out  1   engine accepts a sample
  s_data   in   W   sample x1..x8, in order
  m_valid  out  1   result valid
  m_ready  in   1   downstream accepts result
  m_data   out  W   result y0, then y1
  busy     out  1   high in any state except LOAD
REQ-003 The design SHALL use one clock and an asynchronous, active-low reset (rst_n); no other clock or reset.

Function
REQ-004 All arithmetic SHALL be W-bit two's complement, truncated mod 2^W; no saturation.
REQ-005 Per frame: m_i=x_i*C_IN (i=1..8); n9=m1+m2; n10=m3+m4; n11=m5+m6; n12=m7+m8; n13=n10+z1; n14=n11+z2; n15=n13*C_MID; n16=n14*C_MID; n17=n13*C_MID; n18=n14*C_MID; n19=n15+n16; n20=n17+n18; n21=n19*C_NEG; n22=n20*C_NEG; n23=n19*C_NEG; n24=n20*C_POS; n25=n21+n22; n26=n23+n24; y0=n9+n25; y1=n12+n26.
REQ-006 The datapath SHALL instantiate at most one multiplier and one adder, each single-cycle, time-shared by the schedule.
REQ-007 The FSM SHALL have states LOAD, COMPUTE, OUT0, OUT1.
REQ-008 LOAD: s_ready=1 unless clear=1; a sample SHALL be accepted on each edge with s_valid&&s_ready; a 3-bit counter SHALL index x1..x8; m_i MAY be formed on arrival.
REQ-009 Acceptance of x8 SHALL move LOAD->COMPUTE; COMPUTE SHALL last exactly 16 cycles (4-bit counter 0..15), then go to OUT0.
REQ-010 On the COMPUTE->OUT0 transition, z1<=n19 and z2<=n20 SHALL be updated.
REQ-011 OUT0: m_valid=1, m_data=y0; OUT1: m_valid=1, m_data=y1; each SHALL advance only on m_valid&&m_ready; OUT1 handshake SHALL return to LOAD with counter 0.
REQ-012 While m_ready=0, m_valid and m_data SHALL hold stable; s_ready SHALL be 0 outside LOAD (no overlap of frames).
REQ-013 clear=1 SHALL, on the next edge from any state, zero z1, z2, sample counter and compute counter and enter LOAD; it SHALL override a coincident s_valid or m_ready handshake (no sample accepted, no result consumed).
REQ-014 m_valid SHALL first rise exactly 17 cycles after the edge accepting x8 (16 COMPUTE cycles + registered OUT0).
REQ-015 m_data SHALL be 0 whenever m_valid=0.

Reset
REQ-016 While rst_n=0: state=LOAD, counters=0, z1=z2=0, s_ready=0, m_valid=0, m_data=0, busy=0; s_ready SHALL rise on the first clk edge after rst_n deasserts.
REQ-017 Reset asserted mid-frame or mid-output SHALL abort immediately; the partial frame is lost and no result is emitted.

Verification
REQ-018 After reset, frame x1..x8=1, m_ready=1 -> y0=16'hFF2E, y1=16'h0006; m_valid rises 17 cycles after x8 accepted.
REQ-019 Second identical frame, no clear -> feedback z1=z2=36 applied; y0=16'hFA1E, y1=16'h0006.
REQ-020 clear pulse, then frame x1=16'h8000, x2..x8=0 -> y0=16'h8000 (wrap), y1=16'h0000.
REQ-021 m_ready held 0 for 5 cycles in OUT0 -> m_data=y0 stable, s_ready=0; y1 follows only after the handshake.
REQ-022 clear asserted after x4 accepted, coincident with s_valid -> sample not accepted; next 8 samples form a fresh frame and give the all-ones result of REQ-018.
REQ-023 rst_n pulsed low during COMPUTE -> m_valid stays 0, z1=z2=0; the following all-ones frame gives y0=16'hFF2E.
